// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: bundles the datapath request/response handshake and
// the single-port Data_Memory port driven by dmem_access_ctrl.
//   master : the environment side (datapath plus the RAM's douta)
//   slave  : the controller side
interface dmem_access_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              mem_wea;
   logic [ADDR_W-1:0] mem_addra;
   logic [DATA_W-1:0] mem_dina;
   logic [DATA_W-1:0] mem_douta;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_douta,
      input  req_ready, rsp_valid, rsp_rdata, mem_wea, mem_addra, mem_dina, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_douta,
      output req_ready, rsp_valid, rsp_rdata, mem_wea, mem_addra, mem_dina, busy
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: initiator-side controller for the single-port Data_Memory
// block RAM. Accepts one load/store at a time over a valid/ready handshake,
// drives the RAM port from registers and returns load data on a valid/ready
// response channel. Synchronous active-low reset.
//
// Optional build macro DMEM_INIT_CLEAR_EN: after reset, sweep the whole RAM
// writing zeros before the first request is accepted.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | post-reset zero sweep of the RAM (only with DMEM_INIT_CLEAR_EN)
// IDLE  | ready for a request
// WR    | store issued on the RAM port for one cycle
// RD    | load address presented to the RAM
// WAIT  | waiting out the RAM read latency (down-counter)
// RSP   | load data held on the response channel until rsp_ready
module dmem_access_ctrl #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic             clka,
   input  logic             rst_n,
   dmem_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      WAIT,
      RSP
`ifdef DMEM_INIT_CLEAR_EN
      , CLEAR
`endif
   } state_t;

`ifdef DMEM_INIT_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
`else
   localparam state_t RST_STATE = IDLE;
`endif

   // WAIT lasts READ_LAT cycles: load READ_LAT-1 and leave on terminal count 0
   localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

   state_t            state_q, state_d;
   logic              wea_q, wea_d;
   logic [ADDR_W-1:0] addra_q, addra_d;
   logic [DATA_W-1:0] dina_q, dina_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;

   // state register
   always_ff @(posedge clka) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and next values of the registered RAM port / response outputs
   always_comb begin
      state_d     = state_q;
      wea_d       = 1'b0;
      addra_d     = addra_q;
      dina_d      = dina_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      wait_cnt_d  = wait_cnt_q;
      case (state_q)
`ifdef DMEM_INIT_CLEAR_EN
         // first CLEAR cycle after reset has wea low; the sweep ends once the
         // top address has been written
         CLEAR: begin
            if (wea_q && (&addra_q)) begin
               state_d = IDLE;
            end else begin
               wea_d   = 1'b1;
               dina_d  = '0;
               addra_d = wea_q ? addra_q + ADDR_W'(1) : '0;
            end
         end
`endif
         IDLE: begin
            if (bus.req_valid) begin
               addra_d = bus.req_addr;
               if (bus.req_we) begin
                  wea_d   = 1'b1;
                  dina_d  = bus.req_wdata;
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         WR: begin
            state_d = IDLE;
         end
         RD: begin
            wait_cnt_d = WAIT_INIT;
            state_d    = WAIT;
         end
         WAIT: begin
            if (wait_cnt_q == 2'd0) begin
               rsp_rdata_d = bus.mem_douta;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end
         RSP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // output and wait-counter registers
   always_ff @(posedge clka) begin
      if (!rst_n) begin
         wea_q       <= 1'b0;
         addra_q     <= '0;
         dina_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         wait_cnt_q  <= 2'd0;
      end else begin
         wea_q       <= wea_d;
         addra_q     <= addra_d;
         dina_q      <= dina_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.mem_wea   = wea_q;
   assign bus.mem_addra = addra_q;
   assign bus.mem_dina  = dina_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule
